shift_reg_univ: RTL

Parametrised universal shift register. It is the general successor to the team's fixed 4-bit serial-in/parallel-out register. The block adds:
- configurable width
- bidirectional shifting
- parallel load
- serial outputs at both ends
- a bit counter that flags each completed word

It sits between a serial link front-end and word-wide datapath logic, and serves as a deserializer (shift, then read `pout`) or a serializer (load, then shift out via `sout_hi`/`sout_lo`).

---
 rtl/shift_reg_univ.sv | 94 +++++++++
 1 files changed

// File: rtl/shift_reg_univ.sv
// Parametrised universal shift register: hold, shift up, shift down, or parallel load.
// A shared bit counter pulses word_valid each time WIDTH shifts complete a word.
module shift_reg_univ #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout,
    output logic             sout_hi,
    output logic             sout_lo,
    output logic [CNT_W-1:0] cnt,
    output logic             word_valid
);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] pout_q, pout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wv_q, wv_d;
    logic             shift_s;

    // Next-state selection; both shift directions feed the same word counter.
    always_comb begin
        pout_d  = pout_q;
        cnt_d   = cnt_q;
        wv_d    = 1'b0;
        shift_s = 1'b0;
        if (clr) begin
            pout_d = '0;
            cnt_d  = '0;
        end else if (!en) begin
            pout_d = pout_q;
        end else begin
            case (mode)
                MODE_HOLD: pout_d = pout_q;
                MODE_UP: begin
                    pout_d  = {pout_q[WIDTH-2:0], sin};
                    shift_s = 1'b1;
                end
                MODE_DOWN: begin
                    pout_d  = {sin, pout_q[WIDTH-1:1]};
                    shift_s = 1'b1;
                end
                MODE_LOAD: begin
                    pout_d = pin;
                    cnt_d  = '0;
                end
                default: pout_d = pout_q;
            endcase
            if (shift_s) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    wv_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    wv_d  = 1'b0;
                end
            end else begin
                wv_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pout_q <= '0;
            cnt_q  <= '0;
            wv_q   <= 1'b0;
        end else begin
            pout_q <= pout_d;
            cnt_q  <= cnt_d;
            wv_q   <= wv_d;
        end
    end

    assign pout       = pout_q;
    assign sout_hi    = pout_q[WIDTH-1];
    assign sout_lo    = pout_q[0];
    assign cnt        = cnt_q;
    assign word_valid = wv_q;

endmodule
